// File: rtl/uart_tx.sv
// UART transmitter: start / 8 data LSB-first / optional parity / stop, each bit held Prescale clocks.
// Parity support is built only when the macro UART_TX_PARITY_EN is defined.
module uart_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  output logic       TX_OUT,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [5:0] presc;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] data;
  logic       tx_nxt, busy_nxt;
  logic       accept, bit_done;

`ifdef UART_TX_PARITY_EN
  logic par_en, par_typ;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign accept   = (state == IDLE) && Data_Valid;
  // Prescale of 0 wraps the terminal count to 63, giving 64 cycles per bit.
  assign bit_done = (cnt == presc - 6'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 6'd1;
    bit_nxt   = bit_cnt;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (Data_Valid) state_nxt = START;
      end
      START: if (bit_done) begin
        cnt_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: if (bit_done) begin
        cnt_nxt = '0;
        bit_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        cnt_nxt   = '0;
        state_nxt = STOP;
      end
`endif
      STOP: if (bit_done) begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    // Line level is decoded from the next state so TX_OUT comes straight off a flop.
    case (state_nxt)
      IDLE:   busy_nxt = 1'b0;
      START:  tx_nxt   = 1'b0;
      DATA:   tx_nxt   = data[bit_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt   = parity_bit(data, par_typ);
`endif
      STOP:   tx_nxt   = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
      data    <= '0;
      presc   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en  <= 1'b0;
      par_typ <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      TX_OUT  <= tx_nxt;
      busy    <= busy_nxt;
      if (accept) begin
        data    <= P_DATA;
        presc   <= Prescale;
`ifdef UART_TX_PARITY_EN
        par_en  <= PAR_EN;
        par_typ <= PAR_TYP;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line/busy waveform built per cycle from frame rules.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  bit exp_tx[$];
  bit exp_busy[$];

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_frame(input logic [7:0] d, input bit pe, input bit pt,
                                     input logic [5:0] ps);
    int p;
    int ones;
    bit par;
    bit b[$];
    p = (ps == 6'd0) ? 64 : int'(ps);
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b.push_back(d[i]);
      if (d[i]) ones++;
    end
    par = ((ones % 2) == 1) ^ pt;
    if (pe && PAR_BUILT) b.push_back(par);
    b.push_back(1'b1);
    foreach (b[i]) begin
      for (int k = 0; k < p; k++) begin
        exp_tx.push_back(b[i]);
        exp_busy.push_back(1'b1);
      end
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endfunction

  task automatic check_cycles(input int n, input bit noise, input string tag);
    bit et, eb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      et = exp_tx.pop_front();
      eb = exp_busy.pop_front();
      checks++;
      assert (TX_OUT === et) else begin
        failures++;
        $error("FAIL %s tx (step %0d): observed %b expected %b", tag, i, TX_OUT, et);
      end
      checks++;
      assert (busy === eb) else begin
        failures++;
        $error("FAIL %s busy (step %0d): observed %b expected %b", tag, i, busy, eb);
      end
      if (noise) begin
        P_DATA     = 8'($urandom);
        Prescale   = 6'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        Data_Valid = ($urandom_range(0, 3) == 0);
      end
    end
    if (noise) Data_Valid = 1'b0;
  endtask

  // Called right after a negedge with the DUT idle; ends after checking the idle cycle.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps,
                      input bit noise, input string tag);
    int n;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    n = exp_tx.size();
    push_frame(d, pe, pt, ps);
    n = exp_tx.size() - n;
    push_idle(1);
    check_cycles(1, 1'b0, tag);
    Data_Valid = 1'b0;
    check_cycles(n - 1, noise, tag);
    check_cycles(1, 1'b0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    #2;
    checks++;
    assert (TX_OUT === 1'b1) else begin
      failures++;
      $error("FAIL reset_tx: observed %b expected 1", TX_OUT);
    end
    checks++;
    assert (busy === 1'b0) else begin
      failures++;
      $error("FAIL reset_busy: observed %b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_idle(2);
    check_cycles(2, 1'b0, "idle");

    send(8'hA5, 1'b0, 1'b0, 6'd8,  1'b0, "a5_p8");
    send(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, "a5_even");
    send(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0, "a5_odd");
    send(8'h00, 1'b0, 1'b0, 6'd0,  1'b0, "zero_p64");

    // Data_Valid held high: back-to-back frames with mid-frame input changes.
    P_DATA = 8'h3C; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    push_idle(1);
    push_frame(8'hC3, 1'b0, 1'b0, 6'd8);
    push_idle(1);
    check_cycles(1, 1'b0, "rep");
    P_DATA = 8'hC3; Prescale = 6'd5; PAR_TYP = 1'b1;
    check_cycles(40, 1'b0, "rep");
    Prescale = 6'd8; PAR_TYP = 1'b0;
    check_cycles(40, 1'b0, "rep");
    check_cycles(1, 1'b0, "rep");
    Data_Valid = 1'b0;
    check_cycles(79, 1'b0, "rep");
    check_cycles(1, 1'b0, "rep");

    // Strobe during busy is dropped; the next strobe after busy falls is taken.
    P_DATA = 8'h81; Prescale = 6'd4; PAR_EN = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h81, 1'b0, 1'b0, 6'd4);
    push_idle(1);
    check_cycles(1, 1'b0, "drop");
    Data_Valid = 1'b0;
    check_cycles(12, 1'b0, "drop");
    P_DATA = 8'h55; Data_Valid = 1'b1;
    check_cycles(1, 1'b0, "drop");
    Data_Valid = 1'b0;
    check_cycles(27, 1'b0, "drop");
    send(8'h55, 1'b0, 1'b0, 6'd4, 1'b0, "after_drop");

    for (int f = 0; f < 6; f++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 1'b1, "rand");
    end

    // Asynchronous reset in the middle of data bit 3.
    P_DATA = 8'h96; Prescale = 6'd6; PAR_EN = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h96, 1'b0, 1'b0, 6'd6);
    check_cycles(1, 1'b0, "rst_pre");
    Data_Valid = 1'b0;
    check_cycles(25, 1'b0, "rst_pre");
    #1 reset = 1'b1;
    #1;
    checks++;
    assert (TX_OUT === 1'b1) else begin
      failures++;
      $error("FAIL midrst_tx: observed %b expected 1", TX_OUT);
    end
    checks++;
    assert (busy === 1'b0) else begin
      failures++;
      $error("FAIL midrst_busy: observed %b expected 0", busy);
    end
    #1 reset = 1'b0;
    exp_tx.delete();
    exp_busy.delete();
    push_idle(2);
    check_cycles(2, 1'b0, "rst_idle");
    send(8'h6B, 1'b1, 1'b1, 6'd3, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
